// File: rtl/poly_wave_gen.sv
// poly_wave_gen: bank of phase-accumulator oscillators with per-channel shaping,
// run-time frequency/type writes and an averaging mixer (Phase -> Sample -> Waveform).
module poly_wave_gen #(
  parameter int WAVE_DEPTH = 8,
  parameter int CHANNELS   = 4,
  parameter int CH_BITS    = 2,
  parameter int ACC_WIDTH  = 16,
  parameter int FREQ_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WriteEn,
  input  logic [CH_BITS-1:0]    WriteChannel,
  input  logic [FREQ_WIDTH-1:0] WriteFreq,
  input  logic [1:0]            WriteType,
  input  logic                  PhaseSync,
  output logic [WAVE_DEPTH-1:0] Waveform
);
  localparam int SW = WAVE_DEPTH + CH_BITS;
  logic [FREQ_WIDTH-1:0] freq_q   [CHANNELS];
  logic [FREQ_WIDTH-1:0] freq_d   [CHANNELS];
  logic [1:0]            wtype_q  [CHANNELS];
  logic [1:0]            wtype_d  [CHANNELS];
  logic [ACC_WIDTH-1:0]  phase_q  [CHANNELS];
  logic [ACC_WIDTH-1:0]  phase_d  [CHANNELS];
  logic [WAVE_DEPTH-1:0] sample_q [CHANNELS];
  logic [WAVE_DEPTH-1:0] sample_d [CHANNELS];
  logic [WAVE_DEPTH-1:0] waveform_q, waveform_d, p, t;
  logic [SW-1:0]         sum;
  always_comb begin
    freq_d  = freq_q;
    wtype_d = wtype_q;
    p       = '0;
    t       = '0;
    sum     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      // accumulation uses the pre-write Freq, so the new word takes effect one edge later
      phase_d[c] = PhaseSync ? '0 : phase_q[c] + ACC_WIDTH'(freq_q[c]);
      if (WriteEn && WriteChannel == CH_BITS'(c)) begin
        freq_d[c]  = WriteFreq;
        wtype_d[c] = WriteType;
      end
      p = phase_q[c][ACC_WIDTH-1 -: WAVE_DEPTH];
      t = {p[WAVE_DEPTH-2:0], 1'b0};
      sample_d[c] = wtype_q[c] == 2'd0 ? '0 :
                    wtype_q[c] == 2'd1 ? {WAVE_DEPTH{p[WAVE_DEPTH-1]}} :
                    wtype_q[c] == 2'd2 ? p :
                    p[WAVE_DEPTH-1] ? ~t : t;
      sum = sum + SW'(sample_q[c]);
    end
    waveform_d = sum[SW-1:CH_BITS];
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      freq_q     <= '{default: '0};
      wtype_q    <= '{default: '0};
      phase_q    <= '{default: '0};
      sample_q   <= '{default: '0};
      waveform_q <= '0;
    end else begin
      freq_q     <= freq_d;
      wtype_q    <= wtype_d;
      phase_q    <= phase_d;
      sample_q   <= sample_d;
      waveform_q <= waveform_d;
    end
  end
  assign Waveform = waveform_q;
endmodule

// File: tb/tb_poly_wave_gen.sv
// tb_poly_wave_gen: directed and random stimulus, expected mixer output queued from an
// arithmetic reference model and compared by an independent monitor each cycle.
module tb_poly_wave_gen;
  logic       Clock, Reset, WriteEn, PhaseSync;
  logic [1:0] WriteChannel, WriteType;
  logic [15:0] WriteFreq;
  logic [7:0] Waveform;
  int checks = 0;
  int errors = 0;
  int unsigned m_freq[4], m_type[4], m_phase[4];
  int dl[$];
  int sb[$];

  poly_wave_gen dut (
    .Clock(Clock), .Reset(Reset), .WriteEn(WriteEn), .WriteChannel(WriteChannel),
    .WriteFreq(WriteFreq), .WriteType(WriteType), .PhaseSync(PhaseSync), .Waveform(Waveform)
  );

  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end

  function automatic int shape(int unsigned ph, int unsigned ty);
    int p = int'(ph / 256);
    if (ty == 0) return 0;
    if (ty == 1) return p >= 128 ? 255 : 0;
    if (ty == 2) return p;
    return p < 128 ? 2 * p : 2 * (255 - p) + 1;
  endfunction

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      m_freq[c] = 0; m_type[c] = 0; m_phase[c] = 0;
    end
    dl = '{0, 0};
    sb.delete();
  endtask

  // one clock: drive on the falling edge, advance the model on the rising edge
  task automatic cyc(bit we, int ch, int f, int ty, bit sync);
    int s;
    @(negedge Clock);
    WriteEn = we; WriteChannel = 2'(ch); WriteFreq = 16'(f); WriteType = 2'(ty); PhaseSync = sync;
    @(posedge Clock);
    for (int c = 0; c < 4; c++) m_phase[c] = sync ? 0 : (m_phase[c] + m_freq[c]) % 65536;
    if (we) begin
      m_freq[ch] = f; m_type[ch] = ty;
    end
    s = 0;
    for (int c = 0; c < 4; c++) s += shape(m_phase[c], m_type[c]);
    dl.push_back(s / 4);
    sb.push_back(dl.pop_front());
  endtask

  task automatic idle(int n);
    repeat (n) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic apply_reset(int n);
    @(negedge Clock);
    #2;
    Reset = 0;
    WriteEn = 0; PhaseSync = 0;
    #1;
    chk("reset_async", int'(Waveform), 0);
    model_clear();
    repeat (n) begin
      @(negedge Clock);
      chk("reset_hold", int'(Waveform), 0);
    end
    Reset = 1;
  endtask

  initial begin
    int exp;
    forever begin
      @(posedge Clock);
      #1;
      if (Reset && sb.size() > 0) begin
        exp = sb.pop_front();
        checks++;
        if (Waveform !== 8'(exp)) begin
          errors++;
          $display("FAIL wave got %0d expected %0d at %0t", Waveform, exp, $time);
        end
      end
    end
  end

  initial begin
    Reset = 1; WriteEn = 0; WriteChannel = 0; WriteFreq = 0; WriteType = 0; PhaseSync = 0;
    model_clear();
    apply_reset(5);
    idle(10);
    cyc(1, 0, 16'h0100, 2, 0);
    idle(150);
    apply_reset(1);
    idle(120);
    apply_reset(2);
    cyc(1, 1, 16'h8000, 1, 0);
    idle(12);
    apply_reset(2);
    cyc(1, 2, 16'h0100, 3, 0);
    idle(520);
    apply_reset(2);
    for (int c = 0; c < 4; c++) cyc(1, c, 16'h8000, 1, 0);
    idle(3);
    cyc(0, 0, 0, 0, 1);
    idle(12);
    apply_reset(2);
    cyc(1, 0, 16'h0100, 2, 0);
    idle(20);
    cyc(1, 0, 16'h0200, 2, 1);
    idle(30);
    cyc(1, 0, 16'h0300, 2, 0);
    idle(30);
    cyc(1, 3, 16'h1234, 3, 0);
    cyc(1, 3, 16'h0777, 2, 0);
    idle(10);
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset(1);
      cyc($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
          $urandom_range(0, 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 3)), $urandom_range(0, 31) == 0);
    end
    idle(3);
    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/poly_wave_gen.md
# poly_wave_gen

Parametrised multi-channel successor to the single-voice wave generator top level. It runs CHANNELS independent phase-accumulator oscillators, each with its own run-time frequency word and wave type. Frequency and type are loaded through a single write port instead of being tied off. The channel outputs are shaped, mixed by averaging, and presented as one WAVE_DEPTH-bit sample stream for the audio output stage.

## Interface
- WAVE_DEPTH, 8, output and per-channel sample width (≥ 2)
- CHANNELS, 4, oscillator count; must be a power of 2, ≥ 2
- CH_BITS, 2, log2(CHANNELS); width of the channel select
- ACC_WIDTH, 16, phase accumulator width (≥ WAVE_DEPTH)
- FREQ_WIDTH, 16, tuning word width (≤ ACC_WIDTH)

Ports:
- Clock  in  1  sole clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- WriteEn  in  1  load channel configuration this cycle
- WriteChannel  in  CH_BITS  target channel of the write
- WriteFreq  in  FREQ_WIDTH  tuning word to load
- WriteType  in  2  wave type to load: 0 off, 1 square, 2 saw, 3 triangle
- PhaseSync  in  1  zero all phase accumulators
- Waveform  out  WAVE_DEPTH  mixed output sample

## Operation
- Per-channel registers:
  - Freq[c] (FREQ_WIDTH)
  - Type[c] (2)
  - Phase[c] (ACC_WIDTH)
  - Sample[c] (WAVE_DEPTH)
- Mix register: Waveform.
- Reset (Reset=0, asynchronous): every Freq, Type, Phase and Sample is 0, and Waveform is 0. This holds immediately, also mid-operation, and while the clock is running.
- Accumulate, every cycle: Phase[c] <= Phase[c] + zero-extended Freq[c], modulo 2^ACC_WIDTH. Wrap-around is silent.
- PhaseSync=1: all Phase[c] <= 0 this edge. This overrides accumulation, so no increment is applied that cycle.
- Write (WriteEn=1): Freq[WriteChannel] <= WriteFreq and Type[WriteChannel] <= WriteType.
  - Phase is not touched, so frequency changes are phase-continuous.
  - Other channels are unaffected.
- A write and PhaseSync in the same cycle both take effect.
- Shaping, per channel: let P = Phase[c][ACC_WIDTH-1 -: WAVE_DEPTH], m = P MSB, T = {P[WAVE_DEPTH-2:0],1'b0}.
  - Type 0 off: 0.
  - Type 1 square: m ? 2^WAVE_DEPTH−1 : 0.
  - Type 2 saw: P.
  - Type 3 triangle: m ? ~T : T.
  - Sample[c] <= the shaped value.
- Mix: sum of all Sample[c], computed at WAVE_DEPTH+CH_BITS bits so it cannot overflow. Waveform <= sum >> CH_BITS (truncating average). Off channels still count in the divisor.

## Timing
- Three-stage pipeline: Phase → Sample → Waveform.
- Phase at edge k feeds Sample at edge k+1, which feeds Waveform at edge k+2.
- Write sampled at edge k:
  - Freq/Type are updated at edge k.
  - The accumulation at edge k still uses the old Freq; edge k+1 uses the new one.
  - The new Type first affects Sample at edge k+1 and Waveform at edge k+2.
- PhaseSync at edge k: Phase=0 after edge k, Sample reflects P=0 after k+1, Waveform after k+2.
- After Reset deasserts, the first rising edge accumulates Freq=0, so the output stays 0 until a write.
- No handshake: writes are accepted every cycle, back-to-back. Repeated writes to the same channel are last-write-wins per cycle.

## Test plan
- **Reset behaviour.** Hold Reset=0 for 5 clocks, then release and run 10 clocks with no writes → Waveform=0 throughout. Assert Reset mid-run → Waveform=0 immediately, without waiting for a clock edge.
- **Saw ramp and wrap.** Defaults; write ch0 Freq=0x0100, Type=2 → P(ch0) steps +1 per cycle. Waveform = P/4: 0,0,0,0,1,… reaching 63, then back to 0 after the 256-cycle wrap.
- **Square on one channel.** Write ch1 Freq=0x8000, Type=1 → Sample[1] alternates 255/0 each cycle and Waveform alternates 63/0. Verify the edge k+2 latency from the write.
- **Triangle shape.** Write ch2 Freq=0x0100, Type=3 → Sample[2] = 0,2,…,254,255,253,…,1, then repeats, period 256.
- **Full-scale mix.** Write all 4 channels Freq=0x8000, Type=1, then pulse PhaseSync → Waveform alternates 255/0 in phase. The sum reaches 1020 without overflow.
- **Simultaneous and mid-run writes.**
  - Assert a ch0 write (Freq=0x0200) and PhaseSync in the same cycle → Phase=0, then +0x200 per cycle.
  - Change ch0 Freq mid-ramp without PhaseSync → no phase discontinuity; the step changes at edge k+1.
